fsmc_mc_ctrler: RTL and testbench

Parametrised FSMC/SRAM-style asynchronous bus master and next-generation single-access FSMC controller. Takes transactions from a valid/ready command channel and decodes a chip-select index onto CS_NUM active-low NE lines. It applies separate read and write timings, plus a programmable bus-turnaround gap. Read data is returned on a backpressurable AXIS-like channel; the block sits between a CPU or DMA bridge and external SRAM, PSRAM or LCD devices.

---
 rtl/fsmc_pkg.sv | 35 +++
 rtl/fsmc_phase_cnt.sv | 24 ++
 rtl/fsmc_mc_ctrler.sv | 176 +++++++++++++++++
 tb/tb_fsmc_mc_ctrler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fsmc_pkg.sv
// Shared definitions for the FSMC bus master: state encoding, legal data
// widths and the index-width helper.
package fsmc_pkg;

  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_ADDR = 5'b00010,
    ST_DATA = 5'b00100,
    ST_HOLD = 5'b01000,
    ST_TURN = 5'b10000
  } fsmc_state_e;

  localparam int FSMC_DW_NUM = 3;
  localparam int FSMC_DW_LEGAL [FSMC_DW_NUM] = '{8, 16, 32};

  // Width needed to index n items, never less than 1.
  function automatic int fsmc_clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

  function automatic bit fsmc_dw_legal(input int dw);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < FSMC_DW_NUM; i++) begin
      if (FSMC_DW_LEGAL[i] == dw) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/fsmc_phase_cnt.sv
// 8-bit phase timer: cleared on entry to each bus phase, flags the cycle
// whose count equals the programmed target (target 255 -> 256 cycles).
module fsmc_phase_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic [7:0] target,
  output logic [7:0] count,
  output logic       done
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count + 8'd1;
    end
  end

  assign done = (count == target);

endmodule

// File: rtl/fsmc_mc_ctrler.sv
// Single-access FSMC/SRAM bus master: one command in, one timed bus cycle out
// (ADDR/DATA/HOLD with optional turnaround), read data on a stream channel.
module fsmc_mc_ctrler
  import fsmc_pkg::*;
#(
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 26,
  parameter int CS_NUM           = 4,
  parameter int CS_W             = fsmc_clog2(CS_NUM),
  parameter int simulation_delay = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_cmd_valid,
  output logic                    s_cmd_ready,
  input  logic                    s_cmd_is_rd,
  input  logic [CS_W-1:0]         s_cmd_cs,
  input  logic [ADDR_WIDTH-1:0]   s_cmd_addr,
  input  logic [DATA_WIDTH-1:0]   s_cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_cmd_be,
  input  logic [7:0]              rd_addr_set,
  input  logic [7:0]              rd_data_set,
  input  logic [7:0]              wr_addr_set,
  input  logic [7:0]              wr_data_set,
  input  logic [7:0]              data_hold,
  input  logic [7:0]              bus_turn,
  output logic [DATA_WIDTH-1:0]   m_axis_rd_data,
  output logic                    m_axis_rd_valid,
  input  logic                    m_axis_rd_ready,
  output logic                    trans_done,
  output logic                    trans_err,
  output logic [CS_NUM-1:0]       fsmc_ne,
  output logic [DATA_WIDTH/8-1:0] fsmc_nbl,
  output logic [ADDR_WIDTH-1:0]   fsmc_addr,
  output logic                    fsmc_nwe,
  output logic                    fsmc_noe,
  input  logic [DATA_WIDTH-1:0]   fsmc_data_i,
  output logic [DATA_WIDTH-1:0]   fsmc_data_o,
  output logic [DATA_WIDTH-1:0]   fsmc_data_t
);

  // An illegal parameter set leaves the controller permanently refusing commands.
  localparam bit CFG_OK = fsmc_dw_legal(DATA_WIDTH) && (CS_NUM >= 1) &&
                          (CS_NUM <= 8) && (simulation_delay >= 0);

  fsmc_state_e state, state_nxt;

  logic            accept;
  logic            is_rd_q, cs_ok_q;
  logic [CS_W-1:0] cs_q;
  logic [7:0]      addr_set_q, data_set_q, hold_q, turn_q;

  logic            is_rd_eff, cs_ok_eff, cs_in_ok;
  logic [CS_W-1:0] cs_eff;
  logic            bus_act_nxt;
  logic [CS_NUM-1:0] ne_nxt;

  logic       ph_clear, ph_done;
  logic [7:0] ph_target, ph_count;

  // Command channel: a command transfers on a rising edge where
  // s_cmd_valid & s_cmd_ready; ready only while idle with no read data pending.
  // Read channel: data transfers where m_axis_rd_valid & m_axis_rd_ready; data
  // is held stable while valid is high.
  assign s_cmd_ready = CFG_OK & (state == ST_IDLE) & ~m_axis_rd_valid;
  assign accept      = s_cmd_valid & s_cmd_ready;
  assign cs_in_ok    = (32'(s_cmd_cs) < 32'(CS_NUM));

  // Acceptance-cycle values feed the registered bus outputs on ADDR entry.
  assign is_rd_eff = accept ? s_cmd_is_rd : is_rd_q;
  assign cs_eff    = accept ? s_cmd_cs    : cs_q;
  assign cs_ok_eff = accept ? cs_in_ok    : cs_ok_q;

  always_comb begin
    ph_target = 8'd0;
    case (state)
      ST_ADDR: ph_target = addr_set_q;
      ST_DATA: ph_target = data_set_q;
      ST_HOLD: ph_target = hold_q;
      ST_TURN: ph_target = turn_q - 8'd1;
      default: ph_target = 8'd0;
    endcase
  end

  assign ph_clear = (state_nxt != state);

  fsmc_phase_cnt u_phase_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (ph_clear),
    .target (ph_target),
    .count  (ph_count),
    .done   (ph_done)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)  state_nxt = ST_ADDR;
      ST_ADDR: if (ph_done) state_nxt = ST_DATA;
      ST_DATA: if (ph_done) state_nxt = ST_HOLD;
      ST_HOLD: if (ph_done) state_nxt = (turn_q != 8'd0) ? ST_TURN : ST_IDLE;
      ST_TURN: if (ph_done) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus_act_nxt = (state_nxt == ST_ADDR) | (state_nxt == ST_DATA) |
                       (state_nxt == ST_HOLD);

  always_comb begin
    ne_nxt = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (bus_act_nxt && cs_ok_eff && (cs_eff == CS_W'(i))) ne_nxt[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      fsmc_ne     <= '1;
      fsmc_nwe    <= 1'b1;
      fsmc_noe    <= 1'b1;
      fsmc_data_t <= '1;
    end else begin
      state       <= state_nxt;
      fsmc_ne     <= ne_nxt;
      fsmc_nwe    <= ~((state_nxt == ST_DATA) & ~is_rd_eff);
      fsmc_noe    <= ~(((state_nxt == ST_DATA) | (state_nxt == ST_HOLD)) & is_rd_eff);
      fsmc_data_t <= (bus_act_nxt & ~is_rd_eff) ? '0 : '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_rd_q     <= 1'b0;
      cs_q        <= '0;
      cs_ok_q     <= 1'b0;
      addr_set_q  <= '0;
      data_set_q  <= '0;
      hold_q      <= '0;
      turn_q      <= '0;
      fsmc_addr   <= '0;
      fsmc_nbl    <= '1;
      fsmc_data_o <= '0;
    end else if (accept) begin
      is_rd_q     <= s_cmd_is_rd;
      cs_q        <= s_cmd_cs;
      cs_ok_q     <= cs_in_ok;
      addr_set_q  <= s_cmd_is_rd ? rd_addr_set : wr_addr_set;
      data_set_q  <= s_cmd_is_rd ? rd_data_set : wr_data_set;
      hold_q      <= data_hold;
      turn_q      <= bus_turn;
      fsmc_addr   <= s_cmd_addr;
      fsmc_nbl    <= ~s_cmd_be;
      fsmc_data_o <= s_cmd_wdata;
    end
  end

  // Bus data is captured on the last DATA cycle; valid rises with HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_rd_data  <= '0;
      m_axis_rd_valid <= 1'b0;
    end else if ((state == ST_DATA) && ph_done && is_rd_q) begin
      m_axis_rd_data  <= cs_ok_q ? fsmc_data_i : '0;
      m_axis_rd_valid <= 1'b1;
    end else if (m_axis_rd_valid && m_axis_rd_ready) begin
      m_axis_rd_valid <= 1'b0;
    end
  end

  assign trans_done = (state == ST_HOLD) & ph_done;
  assign trans_err  = trans_done & ~cs_ok_q;

endmodule

// File: tb/tb_fsmc_mc_ctrler.sv
// Directed bench for fsmc_mc_ctrler; CS_NUM=5 so indices 5..7 are unmapped.
module tb_fsmc_mc_ctrler;

  localparam int DW  = 16;
  localparam int AW  = 26;
  localparam int CSN = 5;
  localparam int CSW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic          s_cmd_is_rd = 1'b0;
  logic [CSW-1:0] s_cmd_cs = '0;
  logic [AW-1:0] s_cmd_addr = '0;
  logic [DW-1:0] s_cmd_wdata = '0;
  logic [1:0]    s_cmd_be = '0;
  logic [7:0]    rd_addr_set = '0, rd_data_set = '0, wr_addr_set = '0;
  logic [7:0]    wr_data_set = '0, data_hold = '0, bus_turn = '0;
  logic [DW-1:0] m_axis_rd_data;
  logic          m_axis_rd_valid;
  logic          m_axis_rd_ready = 1'b1;
  logic          trans_done, trans_err;
  logic [CSN-1:0] fsmc_ne;
  logic [1:0]    fsmc_nbl;
  logic [AW-1:0] fsmc_addr;
  logic          fsmc_nwe, fsmc_noe;
  logic [DW-1:0] fsmc_data_i = '0;
  logic [DW-1:0] fsmc_data_o, fsmc_data_t;

  int n_checks = 0;
  int n_errors = 0;

  // per-transaction observations
  int ne_low_n, ne_match_n, nwe_low_n, noe_low_n, dt_low_n;
  int done_n, done_idx, err_n, err_idx, rdv_idx;
  logic [DW-1:0] rdv_data, first_data_o;
  logic [AW-1:0] first_addr;
  logic [1:0]    first_nbl;

  fsmc_mc_ctrler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CS_NUM(CSN), .CS_W(CSW), .simulation_delay(0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_is_rd(s_cmd_is_rd),
    .s_cmd_cs(s_cmd_cs), .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_be(s_cmd_be),
    .rd_addr_set(rd_addr_set), .rd_data_set(rd_data_set), .wr_addr_set(wr_addr_set),
    .wr_data_set(wr_data_set), .data_hold(data_hold), .bus_turn(bus_turn),
    .m_axis_rd_data(m_axis_rd_data), .m_axis_rd_valid(m_axis_rd_valid),
    .m_axis_rd_ready(m_axis_rd_ready),
    .trans_done(trans_done), .trans_err(trans_err),
    .fsmc_ne(fsmc_ne), .fsmc_nbl(fsmc_nbl), .fsmc_addr(fsmc_addr),
    .fsmc_nwe(fsmc_nwe), .fsmc_noe(fsmc_noe),
    .fsmc_data_i(fsmc_data_i), .fsmc_data_o(fsmc_data_o), .fsmc_data_t(fsmc_data_t)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_timing(input logic [7:0] ra, rd, wa, wd, h, bt);
    rd_addr_set = ra; rd_data_set = rd; wr_addr_set = wa;
    wr_data_set = wd; data_hold = h;   bus_turn = bt;
  endtask

  task automatic wait_ready(input string tag);
    int w;
    w = 0;
    while (!s_cmd_ready && w < 1000) begin
      tick;
      w++;
    end
    check(tag, 32'(w >= 1000), 32'd0);
  endtask

  // Presents one command, waits for acceptance, then records ncyc bus cycles
  // starting with the first ADDR cycle (index 1).
  task automatic run_txn(input logic is_rd, input logic [CSW-1:0] cs,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input logic [1:0] be, input int ncyc, input int data_cyc,
                         input logic [DW-1:0] rdata, input bit scramble);
    logic [CSN-1:0] ne_exp;
    ne_exp = '1;
    if (int'(cs) < CSN) ne_exp[cs] = 1'b0;
    s_cmd_valid = 1'b1; s_cmd_is_rd = is_rd; s_cmd_cs = cs;
    s_cmd_addr = addr;  s_cmd_wdata = wd;    s_cmd_be = be;
    wait_ready("accept_timeout");
    tick;
    s_cmd_valid = 1'b0;
    if (scramble) set_timing(8'd200, 8'd200, 8'd200, 8'd200, 8'd200, 8'd200);
    ne_low_n = 0; ne_match_n = 0; nwe_low_n = 0; noe_low_n = 0; dt_low_n = 0;
    done_n = 0; done_idx = 0; err_n = 0; err_idx = 0; rdv_idx = 0; rdv_data = '0;
    for (int k = 1; k <= ncyc; k++) begin
      fsmc_data_i = (k == data_cyc) ? rdata : 16'h0000;
      if (k == 1) begin
        first_addr = fsmc_addr; first_nbl = fsmc_nbl; first_data_o = fsmc_data_o;
      end
      if (fsmc_ne != '1) ne_low_n++;
      if (fsmc_ne == ne_exp) ne_match_n++;
      if (!fsmc_nwe) nwe_low_n++;
      if (!fsmc_noe) noe_low_n++;
      if (fsmc_data_t == '0) dt_low_n++;
      if (trans_done) begin done_n++; if (done_idx == 0) done_idx = k; end
      if (trans_err)  begin err_n++;  if (err_idx == 0)  err_idx = k;  end
      if (m_axis_rd_valid && rdv_idx == 0) begin rdv_idx = k; rdv_data = m_axis_rd_data; end
      tick;
    end
    fsmc_data_i = '0;
  endtask

  initial begin
    int gap, rdy_n, bad_n;

    // reset
    tick; tick;
    check("rst_ne", 32'(fsmc_ne), 32'h1F);
    check("rst_nbl", 32'(fsmc_nbl), 32'h3);
    check("rst_data_t", 32'(fsmc_data_t), 32'hFFFF);
    check("rst_strobes", {30'd0, fsmc_nwe, fsmc_noe}, 32'h3);
    check("rst_addr", 32'(fsmc_addr), 32'h0);
    check("rst_data_o", 32'(fsmc_data_o), 32'h0);
    check("rst_flags", {29'd0, m_axis_rd_valid, trans_done, trans_err}, 32'h0);
    rst_n = 1'b1;
    tick;
    check("rst_ready", 32'(s_cmd_ready), 32'h1);

    // write cs=2, timings changed after acceptance must be ignored
    set_timing(8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0);
    run_txn(1'b0, 3'd2, 26'h12345, 16'hA5A5, 2'b01, 8, 0, 16'h0, 1'b1);
    check("wr_ne_match", 32'(ne_match_n), 32'd6);
    check("wr_ne_low", 32'(ne_low_n), 32'd6);
    check("wr_nwe_low", 32'(nwe_low_n), 32'd3);
    check("wr_noe_low", 32'(noe_low_n), 32'd0);
    check("wr_dt_low", 32'(dt_low_n), 32'd6);
    check("wr_done_idx", 32'(done_idx), 32'd6);
    check("wr_done_n", 32'(done_n), 32'd1);
    check("wr_err_n", 32'(err_n), 32'd0);
    check("wr_addr", 32'(first_addr), 32'h12345);
    check("wr_nbl", 32'(first_nbl), 32'h2);
    check("wr_data_o", 32'(first_data_o), 32'hA5A5);
    check("wr_idle_ne", 32'(fsmc_ne), 32'h1F);

    // read cs=0, minimum timing, top address
    set_timing(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    m_axis_rd_ready = 1'b1;
    run_txn(1'b1, 3'd0, 26'h3FFFFFF, 16'h0, 2'b11, 5, 2, 16'hBEEF, 1'b0);
    check("rd_ne_match", 32'(ne_match_n), 32'd3);
    check("rd_noe_low", 32'(noe_low_n), 32'd2);
    check("rd_nwe_low", 32'(nwe_low_n), 32'd0);
    check("rd_dt_low", 32'(dt_low_n), 32'd0);
    check("rd_valid_idx", 32'(rdv_idx), 32'd3);
    check("rd_data", 32'(rdv_data), 32'hBEEF);
    check("rd_done_idx", 32'(done_idx), 32'd3);
    check("rd_addr", 32'(first_addr), 32'h3FFFFFF);
    check("rd_err_n", 32'(err_n), 32'd0);

    // read with back-pressure, second command queued behind it
    m_axis_rd_ready = 1'b0;
    run_txn(1'b1, 3'd1, 26'h00100, 16'h0, 2'b11, 4, 2, 16'h1234, 1'b0);
    check("bp_valid", 32'(m_axis_rd_valid), 32'h1);
    check("bp_data", 32'(m_axis_rd_data), 32'h1234);
    s_cmd_valid = 1'b1; s_cmd_is_rd = 1'b0; s_cmd_cs = 3'd3;
    s_cmd_addr = 26'h55; s_cmd_wdata = 16'h0F0F; s_cmd_be = 2'b11;
    rdy_n = 0; bad_n = 0;
    for (int k = 0; k < 10; k++) begin
      if (s_cmd_ready) rdy_n++;
      if (!m_axis_rd_valid || m_axis_rd_data != 16'h1234) bad_n++;
      tick;
    end
    check("bp_ready_low", 32'(rdy_n), 32'd0);
    check("bp_stable", 32'(bad_n), 32'd0);
    m_axis_rd_ready = 1'b1;
    tick;
    check("bp_valid_clr", 32'(m_axis_rd_valid), 32'h0);
    check("bp_ready_up", 32'(s_cmd_ready), 32'h1);
    tick;
    s_cmd_valid = 1'b0;
    check("bp_2nd_ne", 32'(fsmc_ne), 32'h17);
    check("bp_2nd_data_o", 32'(fsmc_data_o), 32'h0F0F);
    check("bp_2nd_nbl", 32'(fsmc_nbl), 32'h0);
    wait_ready("bp_idle_timeout");

    // bus turnaround between a write and a read
    set_timing(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd3);
    run_txn(1'b0, 3'd1, 26'h200, 16'h7777, 2'b11, 3, 0, 16'h0, 1'b0);
    check("bt_wr_ne", 32'(ne_match_n), 32'd3);
    s_cmd_valid = 1'b1; s_cmd_is_rd = 1'b1; s_cmd_cs = 3'd1; s_cmd_addr = 26'h204;
    gap = 0; rdy_n = 0;
    while (fsmc_ne == 5'h1F && gap < 50) begin
      if (s_cmd_ready) rdy_n++;
      gap++;
      tick;
    end
    s_cmd_valid = 1'b0;
    check("bt_gap", 32'(gap), 32'd4);
    check("bt_idle_cycles", 32'(rdy_n), 32'd1);
    check("bt_rd_ne", 32'(fsmc_ne), 32'h1D);
    wait_ready("bt_idle_timeout");

    // unmapped chip select
    set_timing(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    run_txn(1'b1, 3'd5, 26'h300, 16'h0, 2'b11, 4, 2, 16'hFFFF, 1'b0);
    check("cs5_ne_low", 32'(ne_low_n), 32'd0);
    check("cs5_noe_low", 32'(noe_low_n), 32'd2);
    check("cs5_rd_data", 32'(rdv_data), 32'h0);
    check("cs5_valid_idx", 32'(rdv_idx), 32'd3);
    check("cs5_done_idx", 32'(done_idx), 32'd3);
    check("cs5_err_idx", 32'(err_idx), 32'd3);
    check("cs5_err_n", 32'(err_n), 32'd1);

    // reset during the DATA phase of a write
    set_timing(8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0);
    s_cmd_valid = 1'b1; s_cmd_is_rd = 1'b0; s_cmd_cs = 3'd2;
    s_cmd_addr = 26'h400; s_cmd_wdata = 16'h5A5A; s_cmd_be = 2'b11;
    wait_ready("mr_accept_timeout");
    tick;
    s_cmd_valid = 1'b0;
    tick;
    check("mr_pre_nwe", 32'(fsmc_nwe), 32'h0);
    check("mr_pre_ne", 32'(fsmc_ne), 32'h1B);
    rst_n = 1'b0;
    #1;
    check("mr_nwe", 32'(fsmc_nwe), 32'h1);
    check("mr_ne", 32'(fsmc_ne), 32'h1F);
    check("mr_data_t", 32'(fsmc_data_t), 32'hFFFF);
    check("mr_addr", 32'(fsmc_addr), 32'h0);
    tick;
    rst_n = 1'b1;
    tick;
    check("mr_ready", 32'(s_cmd_ready), 32'h1);
    check("mr_done", 32'(trans_done), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
